// File: rtl/score_pkg.sv
// Shared helpers and mode constants for the leaderboard tracker.
package score_pkg;

  localparam int MODE_BEST  = 0;
  localparam int MODE_ACCUM = 1;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Saturating add, clamped to the largest w-bit value.
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b, input int w);
    int unsigned lim;
    int unsigned sum;
    lim = (32'd1 << w) - 32'd1;
    sum = a + b;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/score_next.sv
// Combinational next-score unit: keeps the best score or a saturating running total.
module score_next
  import score_pkg::*;
#(
  parameter int SCORE_W = 3,
  parameter int MODE    = MODE_BEST
) (
  input  logic [SCORE_W-1:0] old_score,
  input  logic [SCORE_W-1:0] new_score,
  output logic [SCORE_W-1:0] next_score
);

  always_comb begin
    if (MODE == MODE_ACCUM) begin
      next_score = SCORE_W'(sat_add(32'(old_score), 32'(new_score), SCORE_W));
    end else begin
      next_score = (new_score > old_score) ? new_score : old_score;
    end
  end

endmodule

// File: rtl/leaderboard_tracker.sv
// Per-player score table with an incrementally maintained leader, tie flag and bad-id error pulse.
module leaderboard_tracker
  import score_pkg::*;
#(
  parameter  int NUM_PLAYERS = 8,
  parameter  int SCORE_W     = 3,
  parameter  int ACCUM       = 0,
  localparam int ID_W        = id_width(NUM_PLAYERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               score_valid,
  input  logic [ID_W-1:0]    player_id,
  input  logic [SCORE_W-1:0] new_score,
  input  logic [ID_W-1:0]    rd_id,
  output logic [SCORE_W-1:0] rd_score,
  output logic [ID_W-1:0]    leader_id,
  output logic [SCORE_W-1:0] leader_score,
  output logic               leader_valid,
  output logic               tie,
  output logic               err
);

  localparam logic [ID_W:0] NP = (ID_W+1)'(NUM_PLAYERS);

  logic [SCORE_W-1:0] score_tbl [NUM_PLAYERS];
  logic               in_range;
  logic               rd_in_range;
  logic               accept;
  logic [SCORE_W-1:0] old_score;
  logic [SCORE_W-1:0] upd_score;

  logic [ID_W-1:0]    lid_n;
  logic [SCORE_W-1:0] lscore_n;
  logic               lvalid_n;
  logic               tie_n;
  logic               err_n;

  assign in_range    = {1'b0, player_id} < NP;
  assign rd_in_range = {1'b0, rd_id} < NP;
  assign accept      = score_valid && in_range;
  assign old_score   = in_range ? score_tbl[player_id] : '0;

  score_next #(
    .SCORE_W (SCORE_W),
    .MODE    (ACCUM)
  ) u_next (
    .old_score  (old_score),
    .new_score  (new_score),
    .next_score (upd_score)
  );

  // Table entries never decrease, so comparing against the held leader is exact.
  always_comb begin
    lid_n    = leader_id;
    lscore_n = leader_score;
    lvalid_n = leader_valid;
    tie_n    = tie;
    err_n    = 1'b0;
    if (score_valid && !in_range) begin
      err_n = 1'b1;
    end else if (accept) begin
      if (!leader_valid) begin
        lid_n    = player_id;
        lscore_n = upd_score;
        lvalid_n = 1'b1;
        tie_n    = 1'b0;
      end else if (player_id == leader_id) begin
        lscore_n = upd_score;
        if (upd_score > leader_score) tie_n = 1'b0;
      end else if (upd_score > leader_score) begin
        lid_n    = player_id;
        lscore_n = upd_score;
        tie_n    = 1'b0;
      end else if (upd_score == leader_score) begin
        tie_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score_tbl[i] <= '0;
      rd_score     <= '0;
      leader_id    <= '0;
      leader_score <= '0;
      leader_valid <= 1'b0;
      tie          <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (accept) score_tbl[player_id] <= upd_score;
      rd_score     <= rd_in_range ? score_tbl[rd_id] : '0;
      leader_id    <= lid_n;
      leader_score <= lscore_n;
      leader_valid <= lvalid_n;
      tie          <= tie_n;
      err          <= err_n;
    end
  end

endmodule

// File: tb/tb_leaderboard_tracker.sv
// Drives best (8 players), accumulate (8 players) and best (6 players) trackers with one stimulus stream.
module tb_leaderboard_tracker;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       score_valid;
  logic [2:0] player_id;
  logic [2:0] new_score;
  logic [2:0] rd_id;

  logic [2:0] rd_o  [3];
  logic [2:0] lid_o [3];
  logic [2:0] ls_o  [3];
  logic       lv_o  [3];
  logic       tie_o [3];
  logic       err_o [3];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  leaderboard_tracker #(.NUM_PLAYERS(8), .SCORE_W(3), .ACCUM(0)) u_best8 (
    .clk(clk), .rst(rst), .clear(clear), .score_valid(score_valid),
    .player_id(player_id), .new_score(new_score), .rd_id(rd_id),
    .rd_score(rd_o[0]), .leader_id(lid_o[0]), .leader_score(ls_o[0]),
    .leader_valid(lv_o[0]), .tie(tie_o[0]), .err(err_o[0]));

  leaderboard_tracker #(.NUM_PLAYERS(8), .SCORE_W(3), .ACCUM(1)) u_acc8 (
    .clk(clk), .rst(rst), .clear(clear), .score_valid(score_valid),
    .player_id(player_id), .new_score(new_score), .rd_id(rd_id),
    .rd_score(rd_o[1]), .leader_id(lid_o[1]), .leader_score(ls_o[1]),
    .leader_valid(lv_o[1]), .tie(tie_o[1]), .err(err_o[1]));

  leaderboard_tracker #(.NUM_PLAYERS(6), .SCORE_W(3), .ACCUM(0)) u_best6 (
    .clk(clk), .rst(rst), .clear(clear), .score_valid(score_valid),
    .player_id(player_id), .new_score(new_score), .rd_id(rd_id),
    .rd_score(rd_o[2]), .leader_id(lid_o[2]), .leader_score(ls_o[2]),
    .leader_valid(lv_o[2]), .tie(tie_o[2]), .err(err_o[2]));

  function automatic int np_of(input int c);
    return (c == 2) ? 6 : 8;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: leader is the earliest player to reach the maximum among players that have scored;
  // tie means at least two scored players sit at that maximum.
  int  sc      [3][8];
  bit  touched [3][8];
  int  reach   [3][8];
  int  e_rd [3], e_err [3], e_lv [3], e_ls [3], e_lid [3], e_tie [3];
  int  cyc = 0;
  bit  started = 0;

  always @(posedge clk) begin
    int n, old, nv, best, cnt, lid, lr;
    cyc++;
    started = 1;
    for (int c = 0; c < 3; c++) begin
      n = np_of(c);
      if (rst || clear) begin
        for (int i = 0; i < 8; i++) begin
          sc[c][i] = 0; touched[c][i] = 0; reach[c][i] = 0;
        end
        e_rd[c] = 0; e_err[c] = 0; e_lv[c] = 0; e_ls[c] = 0; e_lid[c] = 0; e_tie[c] = 0;
      end else begin
        e_rd[c]  = (int'(rd_id) < n) ? sc[c][rd_id] : 0;
        e_err[c] = (score_valid && int'(player_id) >= n) ? 1 : 0;
        if (score_valid && int'(player_id) < n) begin
          old = sc[c][player_id];
          if (c == 1) nv = (old + int'(new_score) > 7) ? 7 : old + int'(new_score);
          else        nv = (int'(new_score) > old) ? int'(new_score) : old;
          if (!touched[c][player_id] || nv > old) reach[c][player_id] = cyc;
          touched[c][player_id] = 1;
          sc[c][player_id] = nv;
        end
        best = -1;
        for (int i = 0; i < n; i++) if (touched[c][i] && sc[c][i] > best) best = sc[c][i];
        cnt = 0; lid = 0; lr = 1 << 30;
        for (int i = 0; i < n; i++) begin
          if (touched[c][i] && sc[c][i] == best) begin
            cnt++;
            if (reach[c][i] < lr) begin lr = reach[c][i]; lid = i; end
          end
        end
        e_lv[c]  = (best >= 0) ? 1 : 0;
        e_ls[c]  = (best >= 0) ? best : 0;
        e_lid[c] = lid;
        e_tie[c] = (cnt >= 2) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("rd_score[%0d]", c),     int'(rd_o[c]),  e_rd[c]);
        chk($sformatf("leader_id[%0d]", c),    int'(lid_o[c]), e_lid[c]);
        chk($sformatf("leader_score[%0d]", c), int'(ls_o[c]),  e_ls[c]);
        chk($sformatf("leader_valid[%0d]", c), int'(lv_o[c]),  e_lv[c]);
        chk($sformatf("tie[%0d]", c),          int'(tie_o[c]), e_tie[c]);
        chk($sformatf("err[%0d]", c),          int'(err_o[c]), e_err[c]);
      end
    end
  end

  // Inputs change on the falling edge; returns on the next falling edge with outputs settled.
  task automatic step(input bit v, input int id, input int s, input int rd, input bit clr, input bit r);
    score_valid = v;
    player_id   = id[2:0];
    new_score   = s[2:0];
    rd_id       = rd[2:0];
    clear       = clr;
    rst         = r;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; score_valid = 1'b0;
    player_id = '0; new_score = '0; rd_id = '0;
    repeat (2) @(negedge clk);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_reset_lv", int'(lv_o[0]), 0);
    chk("lit_reset_ls", int'(ls_o[1]), 0);

    // best mode sequence
    step(1, 0, 3, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0);
    step(1, 2, 6, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 2, 7, 0, 0, 0);
    chk("lit_best_lid", int'(lid_o[0]), 2);
    chk("lit_best_ls",  int'(ls_o[0]), 7);
    chk("lit_best_rd0", int'(rd_o[0]), 3);
    chk("lit_best_tie", int'(tie_o[0]), 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 7, 0, 0);

    // tie then overtake
    step(0, 0, 0, 0, 1, 0);
    step(1, 3, 5, 0, 0, 0);
    step(1, 4, 5, 0, 0, 0);
    chk("lit_tie_lid", int'(lid_o[0]), 3);
    chk("lit_tie_flag", int'(tie_o[0]), 1);
    step(1, 4, 6, 0, 0, 0);
    chk("lit_over_lid", int'(lid_o[0]), 4);
    chk("lit_over_ls",  int'(ls_o[0]), 6);
    chk("lit_over_tie", int'(tie_o[0]), 0);

    // accumulate with saturation
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 5, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("lit_acc_rd1", int'(rd_o[1]), 7);
    chk("lit_acc_ls",  int'(ls_o[1]), 7);

    // out-of-range id on the six-player tracker
    step(0, 0, 0, 0, 1, 0);
    step(1, 7, 5, 7, 0, 0);
    chk("lit_bad_err", int'(err_o[2]), 1);
    chk("lit_bad_lv",  int'(lv_o[2]), 0);
    step(0, 0, 0, 7, 0, 0);
    chk("lit_bad_err_off", int'(err_o[2]), 0);
    step(1, 6, 3, 6, 0, 0);
    step(1, 6, 4, 6, 0, 0);

    // clear beats a same-cycle score
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 7, 0, 0, 0);
    step(1, 2, 6, 2, 1, 0);
    chk("lit_clr_lv", int'(lv_o[0]), 0);
    chk("lit_clr_ls", int'(ls_o[0]), 0);
    step(0, 0, 0, 2, 0, 0);
    chk("lit_clr_rd2", int'(rd_o[0]), 0);

    // back-to-back then reset mid-stream
    step(1, 0, 2, 0, 0, 0);
    step(1, 0, 5, 0, 0, 0);
    step(1, 1, 5, 0, 0, 0);
    chk("lit_b2b_lid", int'(lid_o[0]), 0);
    chk("lit_b2b_ls",  int'(ls_o[0]), 5);
    chk("lit_b2b_tie", int'(tie_o[0]), 1);
    step(1, 3, 7, 0, 0, 1);
    chk("lit_rst_lv", int'(lv_o[0]), 0);
    chk("lit_rst_ls", int'(ls_o[0]), 0);

    // zero score sets leader_valid without a tie against idle entries
    step(1, 5, 0, 0, 0, 0);
    chk("lit_zero_lv",  int'(lv_o[0]), 1);
    chk("lit_zero_tie", int'(tie_o[0]), 0);
    step(1, 2, 0, 5, 0, 0);

    // mixed traffic checked against the model every cycle
    for (int k = 0; k < 80; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 24) == 0, 1'b0);
    end
    step(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
